fp_divider_iterative: RTL and testbench

Iterative IEEE-754 single-precision divider; the inverse-operation companion to fp_multiplier_pipelined, sharing its operand/result/flag conventions.
Computes result = a / b with round-to-nearest-even, flush-to-zero on denormals, and the same overflow/underflow/inf/nan flags plus div_by_zero.
Multi-cycle restoring mantissa division behind a start/busy/done handshake. One operation in flight at a time.

---
 rtl/fp_pkg.sv | 38 +++
 rtl/fp_div_mant_core.sv | 66 ++++++
 rtl/fp_divider_iterative.sv | 253 +++++++++++++++++++++++++
 tb/tb_fp_divider_iterative.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision format constants, field helpers and the divider state encoding.
package fp_pkg;

    localparam int unsigned ExpW  = 8;
    localparam int unsigned ManW  = 23;
    localparam int unsigned WordW = 1 + ExpW + ManW;

    // Exponent bias for a given exponent field width.
    function automatic int unsigned bias_of(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    localparam int unsigned Bias = bias_of(ExpW);

    localparam logic [WordW-1:0] QNAN    = 32'h7FC00000;
    localparam logic [WordW-1:0] POS_INF = 32'h7F800000;

    function automatic logic fp_sign(input logic [WordW-1:0] w);
        return w[WordW-1];
    endfunction

    function automatic logic [ExpW-1:0] fp_exp(input logic [WordW-1:0] w);
        return w[WordW-2:ManW];
    endfunction

    function automatic logic [ManW-1:0] fp_frac(input logic [WordW-1:0] w);
        return w[ManW-1:0];
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StDivide,
        StRound,
        StDone
    } div_state_e;

endpackage

// File: rtl/fp_div_mant_core.sv
// Iterative restoring mantissa divider: one quotient bit per cycle, MSB first.
// The load cycle already performs the first iteration so the full quotient is
// ready MAN_W+3 edges after load.
module fp_div_mant_core #(
    parameter int unsigned MAN_W = 23
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [MAN_W:0]   ma_i,
    input  logic [MAN_W:0]   mb_i,
    output logic [MAN_W+2:0] q_o,
    output logic             rem_nz_o,
    output logic             finished_o
);

    localparam int unsigned Iters = MAN_W + 3;
    localparam int unsigned CntW  = $clog2(Iters + 1);

    // Partial remainder is always < 2*mb, so MAN_W+2 bits hold it.
    logic [MAN_W+1:0] r_q, r_d, r_in, r_sub, mb_ext;
    logic [MAN_W+2:0] q_q, q_d, q_in;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             q_bit;

    assign mb_ext = {1'b0, mb_i};

    // One compare/subtract/shift step whenever loading or iterations remain.
    always_comb begin
        r_d   = r_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        r_in  = load_i ? {1'b0, ma_i} : r_q;
        q_in  = load_i ? '0 : q_q;
        q_bit = 1'b0;
        r_sub = r_in;
        if (load_i || (cnt_q != '0)) begin
            if (r_in >= mb_ext) begin
                q_bit = 1'b1;
                r_sub = r_in - mb_ext;
            end
            // r_sub < mb here, so the shift never loses a bit.
            r_d   = r_sub << 1;
            q_d   = (q_in << 1) | {{(MAN_W + 2){1'b0}}, q_bit};
            cnt_d = load_i ? CntW'(Iters - 1) : cnt_q - CntW'(1);
        end
    end

    // Remainder, quotient and iteration counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q   <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            r_q   <= r_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_o        = q_q;
    assign rem_nz_o   = (r_q != '0);
    assign finished_o = (cnt_q == '0) && !load_i;

endmodule

// File: rtl/fp_divider_iterative.sv
// Iterative IEEE-754 divider: start/busy/done handshake, RNE rounding, flush-to-zero.
module fp_divider_iterative
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = ExpW,
    parameter int unsigned MAN_W = ManW
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [EXP_W+MAN_W:0]   a_i,
    input  logic [EXP_W+MAN_W:0]   b_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [EXP_W+MAN_W:0]   result_o,
    output logic                   overflow_o,
    output logic                   underflow_o,
    output logic                   inf_o,
    output logic                   nan_o,
    output logic                   div_by_zero_o
);

    localparam int unsigned W   = 1 + EXP_W + MAN_W;
    localparam int unsigned ESW = EXP_W + 2;

    localparam logic signed [ESW-1:0] BiasS    = ESW'(bias_of(EXP_W));
    localparam logic signed [ESW-1:0] ExpMaxS  = ESW'((32'd1 << EXP_W) - 32'd1);
    localparam logic signed [ESW-1:0] ExpZeroS = '0;
    localparam logic signed [ESW-1:0] OneS     = ESW'(1);

    localparam logic [W-1:0] QnanW  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
    localparam logic [W-2:0] InfMag = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    div_state_e state_q, state_d;

    logic [W-1:0]           a_q, a_d, b_q, b_d;
    logic                   sign_q, sign_d;
    logic signed [ESW-1:0]  exp_q, exp_d;
    logic [W-1:0]           result_q, result_d;
    logic                   ovf_q, ovf_d, uf_q, uf_d, inf_q, inf_d;
    logic                   nan_q, nan_d, dbz_q, dbz_d;

    // Operand fields of the captured operands.
    logic                   sa, sb;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       fa, fb;
    logic                   a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    assign sa = a_q[W-1];
    assign sb = b_q[W-1];
    assign ea = a_q[W-2:MAN_W];
    assign eb = b_q[W-2:MAN_W];
    assign fa = a_q[MAN_W-1:0];
    assign fb = b_q[MAN_W-1:0];

    // Exponent zero is treated as zero regardless of fraction (FTZ on inputs).
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);

    // Mantissa divider core.
    logic             core_load, core_finished, core_rem_nz;
    logic [MAN_W+2:0] core_q;

    fp_div_mant_core #(
        .MAN_W(MAN_W)
    ) u_core (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (core_load),
        .ma_i      ({1'b1, fa}),
        .mb_i      ({1'b1, fb}),
        .q_o       (core_q),
        .rem_nz_o  (core_rem_nz),
        .finished_o(core_finished)
    );

    // Special-case classification, in priority order.
    logic         is_special, spec_inf, spec_nan, spec_dbz;
    logic [W-1:0] spec_result;
    logic         sign_x;

    always_comb begin
        sign_x      = sa ^ sb;
        is_special  = 1'b1;
        spec_result = '0;
        spec_inf    = 1'b0;
        spec_nan    = 1'b0;
        spec_dbz    = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_result = QnanW;
            spec_nan    = 1'b1;
        end else if (b_zero && !a_inf) begin
            spec_result = {sign_x, InfMag};
            spec_inf    = 1'b1;
            spec_dbz    = 1'b1;
        end else if (a_inf) begin
            spec_result = {sign_x, InfMag};
            spec_inf    = 1'b1;
        end else if (a_zero || b_inf) begin
            spec_result = {sign_x, {(W - 1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

    // Normalize the raw quotient, round to nearest even, then range-check.
    logic [MAN_W:0]        mant;
    logic [MAN_W+1:0]      mant_inc;
    logic [MAN_W-1:0]      frac_fin;
    logic                  guard, sticky, round_up;
    logic signed [ESW-1:0] e_adj, e_fin;
    logic [W-1:0]          rnd_result;
    logic                  rnd_ovf, rnd_uf;

    always_comb begin
        if (core_q[MAN_W+2]) begin
            mant   = core_q[MAN_W+2:2];
            guard  = core_q[1];
            sticky = core_q[0] | core_rem_nz;
            e_adj  = exp_q;
        end else begin
            mant   = core_q[MAN_W+1:1];
            guard  = core_q[0];
            sticky = core_rem_nz;
            e_adj  = exp_q - OneS;
        end
        round_up = guard & (sticky | mant[0]);
        mant_inc = {1'b0, mant} + {{(MAN_W + 1){1'b0}}, round_up};
        if (mant_inc[MAN_W+1]) begin
            // Carry out means the mantissa became exactly 2.0.
            frac_fin = mant_inc[MAN_W:1];
            e_fin    = e_adj + OneS;
        end else begin
            frac_fin = mant_inc[MAN_W-1:0];
            e_fin    = e_adj;
        end
        rnd_ovf = 1'b0;
        rnd_uf  = 1'b0;
        if (e_fin >= ExpMaxS) begin
            rnd_result = {sign_q, InfMag};
            rnd_ovf    = 1'b1;
        end else if (e_fin <= ExpZeroS) begin
            rnd_result = {sign_q, {(W - 1){1'b0}}};
            rnd_uf     = 1'b1;
        end else begin
            rnd_result = {sign_q, e_fin[EXP_W-1:0], frac_fin};
        end
    end

    // Control FSM next state and registered-output next values.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        uf_d      = uf_q;
        inf_d     = inf_q;
        nan_d     = nan_q;
        dbz_d     = dbz_q;
        core_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    state_d = StUnpack;
                end
            end
            StUnpack: begin
                sign_d = sign_x;
                if (is_special) begin
                    result_d = spec_result;
                    ovf_d    = 1'b0;
                    uf_d     = 1'b0;
                    inf_d    = spec_inf;
                    nan_d    = spec_nan;
                    dbz_d    = spec_dbz;
                    state_d  = StDone;
                end else begin
                    exp_d     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BiasS;
                    core_load = 1'b1;
                    state_d   = StDivide;
                end
            end
            StDivide: begin
                if (core_finished) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                result_d = rnd_result;
                ovf_d    = rnd_ovf;
                uf_d     = rnd_uf;
                inf_d    = rnd_ovf;
                nan_d    = 1'b0;
                dbz_d    = 1'b0;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            uf_q     <= 1'b0;
            inf_q    <= 1'b0;
            nan_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            uf_q     <= uf_d;
            inf_q    <= inf_d;
            nan_q    <= nan_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign result_o      = result_q;
    assign overflow_o    = ovf_q;
    assign underflow_o   = uf_q;
    assign inf_o         = inf_q;
    assign nan_o         = nan_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_fp_divider_iterative.sv
// Directed bench for fp_divider_iterative: vector table plus handshake and reset sequences.
module tb_fp_divider_iterative;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, overflow, underflow, inf, nan, dbz;
    logic [31:0] result;

    fp_divider_iterative dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .a_i          (a),
        .b_i          (b),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .overflow_o   (overflow),
        .underflow_o  (underflow),
        .inf_o        (inf),
        .nan_o        (nan),
        .div_by_zero_o(dbz)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Flag vector layout: {overflow, underflow, inf, nan, div_by_zero}
    localparam logic [4:0] FNone = 5'b00000;
    localparam logic [4:0] FOvf  = 5'b10000;
    localparam logic [4:0] FUf   = 5'b01000;
    localparam logic [4:0] FInf  = 5'b00100;
    localparam logic [4:0] FNan  = 5'b00010;
    localparam logic [4:0] FDbz  = 5'b00001;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flg;
        logic [5:0]  lat;
    } vec_t;

    localparam int NVec = 16;
    vec_t vecs[NVec];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {overflow, underflow, inf, nan, dbz};
    endfunction

    // Issue one operation and follow it to done (bounded wait).
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] res, output logic [4:0] flg, output int lat,
                         output logic busy_ok, output logic pulse_ok);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_ok  = busy;
        lat      = -1;
        res      = '0;
        flg      = '0;
        pulse_ok = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = i;
                res = result;
                flg = flags_now();
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            pulse_ok = !done && !busy;
        end
    endtask

    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
    logic        bok, pok;
    int          done_cnt;

    initial begin
        vecs[0]  = '{32'h40C00000, 32'h40400000, 32'h40000000, FNone, 6'd28};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, FNone, 6'd28};
        vecs[2]  = '{32'hBF800000, 32'h40400000, 32'hBEAAAAAB, FNone, 6'd28};
        vecs[3]  = '{32'h7F7FFFFF, 32'h00800000, POS_INF,      FOvf | FInf, 6'd28};
        vecs[4]  = '{32'h00800000, 32'h40000000, 32'h00000000, FUf, 6'd28};
        vecs[5]  = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, FNone, 6'd28};
        vecs[6]  = '{32'hC0A00000, 32'h40000000, 32'hC0200000, FNone, 6'd28};
        vecs[7]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, FNone, 6'd28};
        vecs[8]  = '{32'h40000000, 32'h00000000, POS_INF,      FInf | FDbz, 6'd1};
        vecs[9]  = '{32'h7FC00000, 32'h40000000, QNAN,         FNan, 6'd1};
        vecs[10] = '{32'h00000000, 32'h00000000, QNAN,         FNan, 6'd1};
        vecs[11] = '{32'h7F800000, 32'h7F800000, QNAN,         FNan, 6'd1};
        vecs[12] = '{32'h00000001, 32'h40000000, 32'h00000000, FNone, 6'd1};
        vecs[13] = '{32'h7F800000, 32'h00000000, POS_INF,      FInf, 6'd1};
        vecs[14] = '{32'hFF800000, 32'h40000000, 32'hFF800000, FInf, 6'd1};
        vecs[15] = '{32'h40000000, 32'hFF800000, 32'h80000000, FNone, 6'd1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {27'd0, flags_now()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVec; i++) begin
            do_op(vecs[i].a, vecs[i].b, r, f, lat, bok, pok);
            check($sformatf("v%0d result", i), r, vecs[i].res);
            check($sformatf("v%0d flags", i), {27'd0, f}, {27'd0, vecs[i].flg});
            check($sformatf("v%0d latency", i), 32'(lat), {26'd0, vecs[i].lat});
            check($sformatf("v%0d busy", i), {31'd0, bok}, 32'd1);
            check($sformatf("v%0d done pulse", i), {31'd0, pok}, 32'd1);
        end

        // Second start while busy must be ignored.
        @(negedge clk);
        a = 32'h40C00000;
        b = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        done_cnt = 0;
        r = '0;
        for (int i = 7; i <= 80; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = i;
                    r = result;
                end
            end
        end
        check("ignored start result", r, 32'h40000000);
        check("ignored start latency", 32'(lat), 32'd28);
        check("ignored start done count", 32'(done_cnt), 32'd1);

        // Reset mid-divide discards the operation.
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("busy before reset", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset done", {31'd0, done}, 32'd0);
        check("mid reset result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_cnt++;
        end
        check("no done after reset", 32'(done_cnt), 32'd0);

        do_op(32'h40C00000, 32'h40400000, r, f, lat, bok, pok);
        check("post reset result", r, 32'h40000000);
        check("post reset flags", {27'd0, f}, 32'd0);
        check("post reset latency", 32'(lat), 32'd28);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
